eth_rx_checker: RTL

Receive-side frame checker that sits directly downstream of a `mac_rgmii` receive port and consumes its byte stream. It delimits frames, classifies each one as good or bad, and keeps saturating statistics counters plus a sticky error flag for the ILA and register bank. Classification uses:
- MAC status (`fr_good`, `fr_err`);
- frame length bounds;
- an optional incrementing-byte payload pattern matching the test generator.

It runs in the `mac_gtx_clk` domain, after any rx clock-domain crossing.

---
 rtl/eth_rx_checker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/eth_rx_checker.sv
// Receive frame checker: delimits mac_rgmii rx frames, classifies them good/bad
// and keeps saturating statistics plus a sticky error flag.
module eth_rx_checker #(
  parameter int HDR_LEN = 14,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mac_rx_data,
  input  logic        mac_rx_valid,
  input  logic        mac_rx_sof,
  input  logic        mac_rx_eof,
  input  logic        mac_rx_fr_good,
  input  logic        mac_rx_fr_err,
  input  logic        pat_en,
  input  logic        clr,
  output logic [31:0] frame_cnt,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt,
  output logic [31:0] pat_err_cnt,
  output logic [31:0] len_err_cnt,
  output logic [31:0] byte_cnt,
  output logic [15:0] last_len,
  output logic        err,
  output logic        err_pulse,
  output logic [0:0]  fsm_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state;
  logic [15:0] len;
  logic [7:0]  prev_byte;
  logic        pat_on;
  logic        pat_bad;
  logic        mac_err;

  logic        beat_sof;
  logic        beat_eof;
  logic [15:0] len_inc;
  logic        pat_fail;

  assign beat_sof  = mac_rx_valid & mac_rx_sof;
  assign beat_eof  = mac_rx_valid & mac_rx_eof;
  assign len_inc   = (len == 16'hFFFF) ? len : len + 16'd1;
  // In RUN, len equals the index of the byte currently on the bus.
  assign pat_fail  = pat_on && (int'(len) > HDR_LEN) && (mac_rx_data != prev_byte + 8'd1);
  assign fsm_state = state;

  logic        cmp;
  logic [15:0] cmp_len;
  logic        cmp_fr_good;
  logic        cmp_mac;
  logic        cmp_pat;
  logic        cmp_abort;
  logic        cmp_len_bad;
  logic        cmp_bad;

  always_comb begin
    cmp         = 1'b0;
    cmp_len     = len;
    cmp_fr_good = 1'b0;
    cmp_mac     = 1'b0;
    cmp_pat     = 1'b0;
    cmp_abort   = 1'b0;
    if (state == S_IDLE) begin
      if (beat_sof && beat_eof) begin
        cmp         = 1'b1;
        cmp_len     = 16'd1;
        cmp_fr_good = mac_rx_fr_good;
        cmp_mac     = mac_rx_fr_err;
      end
    end else if (beat_eof) begin
      cmp         = 1'b1;
      cmp_len     = len_inc;
      cmp_fr_good = mac_rx_fr_good;
      cmp_mac     = mac_err | mac_rx_fr_err;
      cmp_pat     = pat_bad | pat_fail;
    end else if (beat_sof) begin
      cmp       = 1'b1;
      cmp_mac   = mac_err | mac_rx_fr_err;
      cmp_pat   = pat_bad;
      cmp_abort = 1'b1;
    end
    cmp_len_bad = (int'(cmp_len) < MIN_LEN) || (int'(cmp_len) > MAX_LEN);
    cmp_bad     = !cmp_fr_good || cmp_mac || cmp_len_bad || cmp_pat || cmp_abort;
  end

  // Frame tracking; clr deliberately leaves this alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= 16'd0;
      prev_byte <= 8'd0;
      pat_on    <= 1'b0;
      pat_bad   <= 1'b0;
      mac_err   <= 1'b0;
    end else begin
      if (mac_rx_valid) prev_byte <= mac_rx_data;
      if (state == S_IDLE) begin
        if (beat_sof && !beat_eof) begin
          state   <= S_RUN;
          len     <= 16'd1;
          pat_on  <= pat_en;
          pat_bad <= 1'b0;
          mac_err <= 1'b0;
        end
      end else if (beat_eof) begin
        state <= S_IDLE;
      end else if (beat_sof) begin
        len     <= 16'd1;
        pat_on  <= pat_en;
        pat_bad <= 1'b0;
        mac_err <= 1'b0;
      end else begin
        mac_err <= mac_err | mac_rx_fr_err;
        if (mac_rx_valid) begin
          len     <= len_inc;
          pat_bad <= pat_bad | pat_fail;
        end
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic [32:0] byte_sum;
  logic [31:0] byte_next;
  assign byte_sum  = {1'b0, byte_cnt} + {17'd0, cmp_len};
  assign byte_next = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= 32'd0;
      good_cnt    <= 32'd0;
      bad_cnt     <= 32'd0;
      pat_err_cnt <= 32'd0;
      len_err_cnt <= 32'd0;
      byte_cnt    <= 32'd0;
      last_len    <= 16'd0;
      err         <= 1'b0;
      err_pulse   <= 1'b0;
    end else if (clr) begin
      frame_cnt   <= 32'd0;
      good_cnt    <= 32'd0;
      bad_cnt     <= 32'd0;
      pat_err_cnt <= 32'd0;
      len_err_cnt <= 32'd0;
      byte_cnt    <= 32'd0;
      last_len    <= 16'd0;
      err         <= 1'b0;
      err_pulse   <= 1'b0;
    end else begin
      err_pulse <= cmp && cmp_bad;
      if (cmp) begin
        frame_cnt   <= sat_inc(frame_cnt, 1'b1);
        good_cnt    <= sat_inc(good_cnt, !cmp_bad);
        bad_cnt     <= sat_inc(bad_cnt, cmp_bad);
        pat_err_cnt <= sat_inc(pat_err_cnt, cmp_pat);
        len_err_cnt <= sat_inc(len_err_cnt, cmp_len_bad);
        byte_cnt    <= byte_next;
        last_len    <= cmp_len;
        if (cmp_bad) err <= 1'b1;
      end
    end
  end

endmodule
